// File: rtl/tc_multiway.sv
// tc_multiway: N-approach traffic-light controller with round-robin service
// and sensor-driven green extension. A tick prescaler acts as a clock enable
// for the phase FSM; everything runs on the single CLK domain.
module tc_multiway #(
  parameter int N_WAY        = 4,
  parameter int TICK_DIV     = 500000000,
  parameter int GREEN_MIN    = 2,
  parameter int GREEN_MAX    = 6,
  parameter int YELLOW_TICKS = 1,
  parameter int ALLRED_TICKS = 1
) (
  input  logic                     CLK,
  input  logic                     R,
  input  logic [N_WAY-1:0]         T,
  output logic [3*N_WAY-1:0]       L,
  output logic [$clog2(N_WAY)-1:0] CUR,
  output logic [1:0]               PHASE,
  output logic                     TICK
);

  localparam int CW = $clog2(N_WAY);
  localparam int PW = $clog2(TICK_DIV);
  // The timer is shared by all phases, so it must hold the largest count any
  // phase needs; with the usual settings this is just GREEN_MAX.
  localparam int TIMER_SPAN =
    (GREEN_MAX > YELLOW_TICKS) ?
      ((GREEN_MAX > ALLRED_TICKS) ? GREEN_MAX : ALLRED_TICKS) :
      ((YELLOW_TICKS > ALLRED_TICKS) ? YELLOW_TICKS : ALLRED_TICKS);
  localparam int TW = $clog2(TIMER_SPAN + 1);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_t;

  logic [PW-1:0] presc;
  logic          tick;

  phase_t        phase, phase_d;
  logic [CW-1:0] cur, cur_d;
  logic [CW-1:0] nxt, nxt_d;
  logic [TW-1:0] timer, timer_d;

  logic          other_req;
  logic [CW-1:0] nxt_sel;
  logic [CW-1:0] idx_c;
  logic          found;
  int            t_inc;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Prescaler: free-running 0..TICK_DIV-1 counter producing the timing enable.
  always_ff @(posedge CLK) begin
    if (R) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Request scan: any waiting approach other than cur, and the first one after cur in rotation.
  always_comb begin
    other_req = 1'b0;
    nxt_sel   = cur;
    found     = 1'b0;
    idx_c     = '0;
    for (int k = 1; k < N_WAY; k++) begin
      idx_c = CW'((int'(cur) + k) % N_WAY);
      if (T[idx_c] && !found) begin
        found   = 1'b1;
        nxt_sel = idx_c;
      end
      other_req = other_req | T[idx_c];
    end
  end

  // Next-state logic: phase decisions happen only on tick cycles.
  always_comb begin
    phase_d = phase;
    cur_d   = cur;
    nxt_d   = nxt;
    timer_d = timer;
    t_inc   = int'(timer) + 1;
    if (tick) begin
      case (phase)
        PH_GREEN: begin
          if (t_inc >= GREEN_MIN && other_req && (!T[cur] || t_inc >= GREEN_MAX)) begin
            phase_d = PH_YELLOW;
            nxt_d   = nxt_sel;
            timer_d = '0;
          end else if (t_inc >= GREEN_MAX) begin
            timer_d = TW'(GREEN_MAX);
          end else begin
            timer_d = TW'(t_inc);
          end
        end
        PH_YELLOW: begin
          if (t_inc == YELLOW_TICKS) begin
            timer_d = '0;
            if (ALLRED_TICKS == 0) begin
              phase_d = PH_GREEN;
              cur_d   = nxt;
            end else begin
              phase_d = PH_ALLRED;
            end
          end else begin
            timer_d = TW'(t_inc);
          end
        end
        PH_ALLRED: begin
          if (t_inc == ALLRED_TICKS) begin
            timer_d = '0;
            phase_d = PH_GREEN;
            cur_d   = nxt;
          end else begin
            timer_d = TW'(t_inc);
          end
        end
        default: begin
          phase_d = PH_GREEN;
          timer_d = '0;
        end
      endcase
    end
  end

  // State register: reset wins over any tick on the same edge.
  always_ff @(posedge CLK) begin
    if (R) begin
      phase <= PH_GREEN;
      cur   <= '0;
      nxt   <= '0;
      timer <= '0;
    end else begin
      phase <= phase_d;
      cur   <= cur_d;
      nxt   <= nxt_d;
      timer <= timer_d;
    end
  end

  // Light decode from registered phase and cur: only the served approach leaves red.
  always_comb begin
    L = '0;
    for (int i = 0; i < N_WAY; i++) begin
      L[3*i +: 3] = 3'b100;
      if (CW'(i) == cur) begin
        if (phase == PH_GREEN) begin
          L[3*i +: 3] = 3'b001;
        end else if (phase == PH_YELLOW) begin
          L[3*i +: 3] = 3'b010;
        end
      end
    end
  end

  assign CUR   = cur;
  assign PHASE = phase;
  assign TICK  = tick;

endmodule

// File: tb/tb_tc_multiway.sv
// Testbench for tc_multiway: scoreboard of per-cycle expected outputs for a
// main instance (ALLRED_TICKS=1) and a variant without the all-red phase.
module tb_tc_multiway;

  logic        CLK;
  logic        R;
  logic [3:0]  T;
  logic [11:0] L_a, L_b;
  logic [1:0]  CUR_a, CUR_b;
  logic [1:0]  PHASE_a, PHASE_b;
  logic        TICK_a, TICK_b;

  typedef struct {
    int          cyc;
    bit          alt;
    logic [11:0] l;
    logic [1:0]  cur;
    logic [1:0]  phase;
    logic        tick;
  } exp_t;

  exp_t  sb[$];
  int    cyc;
  int    checks;
  int    errors;
  string test_name;

  tc_multiway #(
    .N_WAY(4), .TICK_DIV(4), .GREEN_MIN(2), .GREEN_MAX(5),
    .YELLOW_TICKS(2), .ALLRED_TICKS(1)
  ) dut_a (
    .CLK(CLK), .R(R), .T(T), .L(L_a), .CUR(CUR_a), .PHASE(PHASE_a), .TICK(TICK_a)
  );

  tc_multiway #(
    .N_WAY(4), .TICK_DIV(4), .GREEN_MIN(2), .GREEN_MAX(5),
    .YELLOW_TICKS(2), .ALLRED_TICKS(0)
  ) dut_b (
    .CLK(CLK), .R(R), .T(T), .L(L_b), .CUR(CUR_b), .PHASE(PHASE_b), .TICK(TICK_b)
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [11:0] light_word(int ph, int c);
    logic [11:0] lw;
    lw = 12'b100_100_100_100;
    if (ph == 0) lw[3*c +: 3] = 3'b001;
    else if (ph == 1) lw[3*c +: 3] = 3'b010;
    return lw;
  endfunction

  // Queue expected outputs for cycles from..to (tick every 4th cycle from 3).
  task automatic push_seg(input int from, input int to, input bit alt,
                          input int ph, input int c);
    exp_t e;
    for (int k = from; k <= to; k++) begin
      e.cyc   = k;
      e.alt   = alt;
      e.l     = light_word(ph, c);
      e.cur   = 2'(c);
      e.phase = 2'(ph);
      e.tick  = ((k % 4) == 3);
      sb.push_back(e);
    end
  endtask

  // Step to the given cycle, comparing every scoreboard entry that falls due.
  task automatic advance_to(input int target);
    exp_t        e;
    logic [11:0] ol;
    logic [1:0]  oc, op;
    logic        ot;
    while (cyc < target) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e  = sb.pop_front();
        ol = e.alt ? L_b : L_a;
        oc = e.alt ? CUR_b : CUR_a;
        op = e.alt ? PHASE_b : PHASE_a;
        ot = e.alt ? TICK_b : TICK_a;
        checks++;
        if (ol !== e.l) begin
          errors++;
          $display("[TB] FAIL %s L cycle %0d: got %b want %b", test_name, cyc, ol, e.l);
        end
        checks++;
        if (oc !== e.cur) begin
          errors++;
          $display("[TB] FAIL %s CUR cycle %0d: got %0d want %0d", test_name, cyc, oc, e.cur);
        end
        checks++;
        if (op !== e.phase) begin
          errors++;
          $display("[TB] FAIL %s PHASE cycle %0d: got %0d want %0d", test_name, cyc, op, e.phase);
        end
        checks++;
        if (ot !== e.tick) begin
          errors++;
          $display("[TB] FAIL %s TICK cycle %0d: got %b want %b", test_name, cyc, ot, e.tick);
        end
      end
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic finish_test(input int last);
    advance_to(last + 1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s leftover: got %0d unchecked entries want 0", test_name, sb.size());
      sb.delete();
    end
  endtask

  // Reset with one active edge; returns sitting in cycle 0.
  task automatic do_reset(input logic [3:0] t_val);
    @(negedge CLK);
    R = 1'b1;
    T = t_val;
    @(negedge CLK);
    R   = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    test_name = "reset_idle";
    do_reset(4'b0000);
    push_seg(0, 199, 1'b0, 0, 0);
    finish_test(199);
  endtask

  task automatic test_single_request();
    test_name = "single_request";
    do_reset(4'b0100);
    push_seg(0, 7, 1'b0, 0, 0);
    push_seg(8, 15, 1'b0, 1, 0);
    push_seg(16, 19, 1'b0, 2, 0);
    push_seg(20, 27, 1'b0, 0, 2);
    finish_test(27);
  endtask

  task automatic test_contention();
    test_name = "contention";
    do_reset(4'b0101);
    push_seg(0, 19, 1'b0, 0, 0);
    push_seg(20, 27, 1'b0, 1, 0);
    push_seg(28, 31, 1'b0, 2, 0);
    push_seg(32, 51, 1'b0, 0, 2);
    push_seg(52, 59, 1'b0, 1, 2);
    push_seg(60, 63, 1'b0, 2, 2);
    push_seg(64, 71, 1'b0, 0, 0);
    finish_test(71);
  endtask

  task automatic test_round_robin();
    test_name = "round_robin";
    do_reset(4'b0010);
    push_seg(0, 7, 1'b0, 0, 0);
    push_seg(8, 15, 1'b0, 1, 0);
    push_seg(16, 19, 1'b0, 2, 0);
    push_seg(20, 27, 1'b0, 0, 1);
    push_seg(28, 35, 1'b0, 1, 1);
    push_seg(36, 39, 1'b0, 2, 1);
    push_seg(40, 47, 1'b0, 0, 3);
    advance_to(20);
    T = 4'b1001;
    advance_to(30);
    T = 4'b0001;
    finish_test(47);
  endtask

  task automatic test_reset_mid_yellow();
    test_name = "reset_mid_yellow";
    do_reset(4'b0100);
    push_seg(0, 7, 1'b0, 0, 0);
    push_seg(8, 10, 1'b0, 1, 0);
    advance_to(11);
    R = 1'b1;
    @(negedge CLK);
    R   = 1'b0;
    cyc = 0;
    push_seg(0, 7, 1'b0, 0, 0);
    push_seg(8, 11, 1'b0, 1, 0);
    finish_test(11);
  endtask

  task automatic test_no_allred();
    test_name = "no_allred";
    do_reset(4'b0010);
    push_seg(0, 7, 1'b1, 0, 0);
    push_seg(8, 15, 1'b1, 1, 0);
    push_seg(16, 23, 1'b1, 0, 1);
    finish_test(23);
  endtask

  // Test sequence
  initial begin
    R      = 1'b1;
    T      = 4'b0000;
    cyc    = 0;
    checks = 0;
    errors = 0;
    test_reset();
    test_single_request();
    test_contention();
    test_round_robin();
    test_reset_mid_yellow();
    test_no_allred();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
